// File: rtl/uart_alu_sequencer_if.sv
// Handshake bundle between the sequencer, the UART RX/TX FIFOs and the ALU.
// master: the sequencer side. slave: FIFOs plus ALU side.
interface uart_alu_sequencer_if #(
    parameter int unsigned DBIT = 8
);
    logic            rx_empty;
    logic [DBIT-1:0] r_data;
    logic            rd_uart;
    logic            tx_full;
    logic [DBIT-1:0] w_data;
    logic            wr_uart;
    logic [DBIT-1:0] a;
    logic [DBIT-1:0] b;
    logic [DBIT-1:0] op;
    logic [DBIT-1:0] w;
    logic [DBIT-1:0] led;

    modport master (
        input  rx_empty, r_data, tx_full, w,
        output rd_uart, w_data, wr_uart, a, b, op, led
    );

    modport slave (
        output rx_empty, r_data, tx_full, w,
        input  rd_uart, w_data, wr_uart, a, b, op, led
    );
endinterface

// File: rtl/uart_alu_sequencer.sv
// Control FSM between the UART FIFOs and a combinational ALU.
// Pops A, B, OP from the RX FIFO, lets the ALU settle for one cycle, then pushes the
// result into the TX FIFO and mirrors it on led.
// Optional feature: define UART_ALU_TIMEOUT_EN to drop a partial frame after
// TIMEOUT_CYCLES idle cycles in WAIT_B/WAIT_OP.
module uart_alu_sequencer #(
    parameter int unsigned DBIT           = 8,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input logic                  clk,
    input logic                  reset,
    uart_alu_sequencer_if.master io_bus
);

    typedef enum logic [2:0] {
        StWaitA  = 3'd0,
        StWaitB  = 3'd1,
        StWaitOp = 3'd2,
        StExec   = 3'd3,
        StSend   = 3'd4
    } state_e;

    state_e          r_state;
    state_e          w_state_next;
    logic [DBIT-1:0] r_a;
    logic [DBIT-1:0] r_b;
    logic [DBIT-1:0] r_op;
    logic [DBIT-1:0] r_result;
    logic [DBIT-1:0] r_led;
    logic            w_rd_uart;
    logic            w_wr_uart;
    logic            w_timeout;

`ifdef UART_ALU_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT_CYCLES);

    logic [CntW-1:0] r_cnt;
    logic            w_mid_frame;

    assign w_mid_frame = (r_state == StWaitB) || (r_state == StWaitOp);

    // Idle counter: cleared on a pop or outside a partial frame, saturates at CntMax
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (w_rd_uart || !w_mid_frame) begin
            r_cnt <= '0;
        end else if (r_cnt != CntMax) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign w_timeout = w_mid_frame && io_bus.rx_empty && (r_cnt == CntMax);
`else
    assign w_timeout = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= StWaitA;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode; a pending byte wins over an expiring timeout
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StWaitA: begin
                if (!io_bus.rx_empty) w_state_next = StWaitB;
            end
            StWaitB: begin
                if (!io_bus.rx_empty) w_state_next = StWaitOp;
                else if (w_timeout)   w_state_next = StWaitA;
            end
            StWaitOp: begin
                if (!io_bus.rx_empty) w_state_next = StExec;
                else if (w_timeout)   w_state_next = StWaitA;
            end
            StExec: begin
                w_state_next = StSend;
            end
            StSend: begin
                if (!io_bus.tx_full) w_state_next = StWaitA;
            end
            default: begin
                w_state_next = StWaitA;
            end
        endcase
    end

    // FIFO strobes: pure decode of state and FIFO flags, mutually exclusive by state
    always_comb begin
        w_rd_uart = 1'b0;
        w_wr_uart = 1'b0;
        unique case (r_state)
            StWaitA, StWaitB, StWaitOp: w_rd_uart = !io_bus.rx_empty;
            StSend:                     w_wr_uart = !io_bus.tx_full;
            default:                    ;
        endcase
    end

    // Datapath: capture operands on their pop, latch ALU result, mirror sent result
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_a      <= '0;
            r_b      <= '0;
            r_op     <= '0;
            r_result <= '0;
            r_led    <= '0;
        end else begin
            if (w_rd_uart && (r_state == StWaitA))  r_a  <= io_bus.r_data;
            if (w_rd_uart && (r_state == StWaitB))  r_b  <= io_bus.r_data;
            if (w_rd_uart && (r_state == StWaitOp)) r_op <= io_bus.r_data;
            if (r_state == StExec)                  r_result <= io_bus.w;
            if (w_wr_uart)                          r_led    <= r_result;
        end
    end

    assign io_bus.rd_uart = w_rd_uart;
    assign io_bus.wr_uart = w_wr_uart;
    assign io_bus.w_data  = r_result;
    assign io_bus.a       = r_a;
    assign io_bus.b       = r_b;
    assign io_bus.op      = r_op;
    assign io_bus.led     = r_led;

endmodule

// File: tb/tb_uart_alu_sequencer.sv
// Self-checking bench for uart_alu_sequencer: RX FIFO queue model, behavioural ALU,
// TX monitor feeding an observed queue compared against an expected-result queue.
module tb_uart_alu_sequencer;
    localparam int unsigned DBIT           = 8;
    localparam int unsigned TIMEOUT_CYCLES = 100;

    logic clk;
    logic reset;

    uart_alu_sequencer_if #(.DBIT(DBIT)) u_if ();

    uart_alu_sequencer #(
        .DBIT           (DBIT),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .io_bus (u_if.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [DBIT-1:0] rx_q[$];
    logic [DBIT-1:0] exp_q[$];
    logic [DBIT-1:0] obs_q[$];
    int errors = 0;
    int checks = 0;
    int n_rd   = 0;
    int n_wr   = 0;

    // Behavioural ALU (MIPS-style funct codes)
    always_comb begin
        u_if.w = '0;
        case (u_if.op)
            8'h20:   u_if.w = u_if.a + u_if.b;
            8'h22:   u_if.w = u_if.a - u_if.b;
            8'h24:   u_if.w = u_if.a & u_if.b;
            8'h25:   u_if.w = u_if.a | u_if.b;
            8'h26:   u_if.w = u_if.a ^ u_if.b;
            8'h02:   u_if.w = u_if.a >> u_if.b[2:0];
            default: u_if.w = '0;
        endcase
    end

    // RX FIFO model plus strobe monitor: sample at negedge, pop just after posedge
    initial begin
        logic pend;
        u_if.rx_empty = 1'b1;
        u_if.r_data   = '0;
        forever begin
            @(negedge clk);
            pend = u_if.rd_uart;
            if (u_if.rd_uart === 1'b1) begin
                n_rd++;
                checks++;
                if (u_if.rx_empty !== 1'b0 || u_if.wr_uart !== 1'b0) begin
                    errors++;
                    $display("FAIL rd_strobe: rx_empty=%b wr_uart=%b, required 0 and 0",
                             u_if.rx_empty, u_if.wr_uart);
                end
            end
            if (u_if.wr_uart === 1'b1) begin
                n_wr++;
                obs_q.push_back(u_if.w_data);
                checks++;
                if (u_if.tx_full !== 1'b0) begin
                    errors++;
                    $display("FAIL wr_while_full: tx_full=%b, required 0", u_if.tx_full);
                end
            end
            @(posedge clk);
            #1;
            if (pend && rx_q.size() > 0) void'(rx_q.pop_front());
            u_if.rx_empty = (rx_q.size() == 0);
            u_if.r_data   = (rx_q.size() > 0) ? rx_q[0] : '0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic push(input logic [DBIT-1:0] v);
        rx_q.push_back(v);
    endtask

    task automatic wait_obs(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (obs_q.size() >= n) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_rd(input int target, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (n_rd >= target) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({u_if.a, u_if.b, u_if.op, u_if.w_data, u_if.led} !== '0) begin
            errors++;
            $display("FAIL reset_regs: a=%h b=%h op=%h w_data=%h led=%h, required all 00",
                     u_if.a, u_if.b, u_if.op, u_if.w_data, u_if.led);
        end
        checks++;
        if (u_if.rd_uart !== 1'b0 || u_if.wr_uart !== 1'b0) begin
            errors++;
            $display("FAIL reset_strobes: rd=%b wr=%b, required 0 0", u_if.rd_uart, u_if.wr_uart);
        end
        repeat (3) tick();
        reset = 1'b1;
        repeat (3) tick();
        checks++;
        if (n_rd != 0 || n_wr != 0) begin
            errors++;
            $display("FAIL idle_strobes: rd=%0d wr=%0d, required 0 0", n_rd, n_wr);
        end
    endtask

    task automatic test_add();
        bit ok;
        logic [DBIT-1:0] e, o;
        int rd0 = n_rd;
        int wr0 = n_wr;
        push(8'h01); push(8'h03); push(8'h20);
        exp_q.push_back(8'h04);
        wait_obs(1, 50, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL add_wait: no wr_uart, required one"); end
        repeat (3) tick();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 'x;
            checks++;
            if (o !== e) begin errors++; $display("FAIL add_result: w_data=%h, required %h", o, e); end
        end
        checks++;
        if ({u_if.a, u_if.b, u_if.op} !== {8'h01, 8'h03, 8'h20}) begin
            errors++;
            $display("FAIL add_operands: a=%h b=%h op=%h, required 01 03 20",
                     u_if.a, u_if.b, u_if.op);
        end
        checks++;
        if (u_if.led !== 8'h04) begin
            errors++; $display("FAIL add_led: led=%h, required 04", u_if.led);
        end
        checks++;
        if (n_rd - rd0 != 3 || n_wr - wr0 != 1) begin
            errors++;
            $display("FAIL add_counts: rd=%0d wr=%0d, required 3 1", n_rd - rd0, n_wr - wr0);
        end
    endtask

    task automatic test_tx_full();
        bit ok;
        logic [DBIT-1:0] e, o;
        int rd0 = n_rd;
        int wr0 = n_wr;
        u_if.tx_full = 1'b1;
        push(8'h0F); push(8'h03); push(8'h22);
        exp_q.push_back(8'h0C);
        wait_rd(rd0 + 3, 50, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL full_pops: rd=%0d, required 3", n_rd - rd0); end
        repeat (10) tick();
        checks++;
        if (n_wr != wr0 || obs_q.size() != 0) begin
            errors++;
            $display("FAIL full_hold: wr=%0d, required 0", n_wr - wr0);
        end
        u_if.tx_full = 1'b0;
        tick();
        checks++;
        if (obs_q.size() != 1) begin
            errors++;
            $display("FAIL full_release: wr=%0d in first free cycle, required 1", obs_q.size());
        end
        repeat (3) tick();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 'x;
            checks++;
            if (o !== e) begin errors++; $display("FAIL sub_result: w_data=%h, required %h", o, e); end
        end
        checks++;
        if (n_wr - wr0 != 1) begin
            errors++; $display("FAIL sub_count: wr=%0d, required 1", n_wr - wr0);
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        logic [DBIT-1:0] e, o;
        int rd0 = n_rd;
        push(8'h01); push(8'h03); push(8'h20);
        push(8'hF0); push(8'h0F); push(8'h25);
        exp_q.push_back(8'h04);
        exp_q.push_back(8'hFF);
        wait_obs(2, 100, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL b2b_wait: results=%0d, required 2", obs_q.size()); end
        repeat (3) tick();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 'x;
            checks++;
            if (o !== e) begin errors++; $display("FAIL b2b_result: w_data=%h, required %h", o, e); end
        end
        checks++;
        if (n_rd - rd0 != 6 || obs_q.size() != 0) begin
            errors++;
            $display("FAIL b2b_counts: rd=%0d extra_tx=%0d, required 6 0", n_rd - rd0, obs_q.size());
        end
        checks++;
        if (u_if.led !== 8'hFF) begin
            errors++; $display("FAIL b2b_led: led=%h, required ff", u_if.led);
        end
    endtask

    task automatic test_reset_mid_frame();
        bit ok;
        logic [DBIT-1:0] e, o;
        int rd0 = n_rd;
        push(8'h05); push(8'h06);
        wait_rd(rd0 + 2, 30, ok);
        tick();
        checks++;
        if (!ok || u_if.a !== 8'h05 || u_if.b !== 8'h06) begin
            errors++;
            $display("FAIL mid_partial: a=%h b=%h, required 05 06", u_if.a, u_if.b);
        end
        reset = 1'b0;
        #1;
        checks++;
        if ({u_if.a, u_if.b, u_if.op, u_if.w_data, u_if.led, u_if.rd_uart, u_if.wr_uart} !== '0)
        begin
            errors++;
            $display("FAIL mid_reset: a=%h b=%h op=%h w_data=%h led=%h, required all 0",
                     u_if.a, u_if.b, u_if.op, u_if.w_data, u_if.led);
        end
        repeat (2) tick();
        reset = 1'b1;
        tick();
        push(8'h02); push(8'h02); push(8'h20);
        exp_q.push_back(8'h04);
        wait_obs(1, 50, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL mid_wait: no wr_uart, required one"); end
        repeat (3) tick();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 'x;
            checks++;
            if (o !== e) begin errors++; $display("FAIL mid_result: w_data=%h, required %h", o, e); end
        end
        checks++;
        if ({u_if.a, u_if.b, u_if.op} !== {8'h02, 8'h02, 8'h20}) begin
            errors++;
            $display("FAIL mid_operands: a=%h b=%h op=%h, required 02 02 20",
                     u_if.a, u_if.b, u_if.op);
        end
    endtask

    task automatic test_timeout();
        bit ok;
        logic [DBIT-1:0] e, o;
        int rd0 = n_rd;
        push(8'h07);
        wait_rd(rd0 + 1, 20, ok);
        repeat (150) tick();
        checks++;
        if (!ok || obs_q.size() != 0 || u_if.a !== 8'h07) begin
            errors++;
            $display("FAIL idle_hold: tx=%0d a=%h, required 0 07", obs_q.size(), u_if.a);
        end
        push(8'h01); push(8'h02); push(8'h20);
        // Either build ends in result 03: ADD 01+02, or SRL 07>>1
        exp_q.push_back(8'h03);
        wait_obs(1, 50, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL to_wait: no wr_uart, required one"); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 'x;
            checks++;
            if (o !== e) begin errors++; $display("FAIL to_result: w_data=%h, required %h", o, e); end
        end
`ifdef UART_ALU_TIMEOUT_EN
        checks++;
        if ({u_if.a, u_if.b, u_if.op} !== {8'h01, 8'h02, 8'h20}) begin
            errors++;
            $display("FAIL to_operands: a=%h b=%h op=%h, required 01 02 20",
                     u_if.a, u_if.b, u_if.op);
        end
`else
        // Trailing 0x20 is popped as the next A right after SEND; b/op still hold
        checks++;
        if ({u_if.b, u_if.op} !== {8'h01, 8'h02}) begin
            errors++;
            $display("FAIL nto_operands: b=%h op=%h, required 01 02", u_if.b, u_if.op);
        end
`endif
    endtask

    initial begin
        reset        = 1'b0;
        u_if.tx_full = 1'b0;
        test_reset();
        test_add();
        test_tx_full();
        test_back_to_back();
        test_reset_mid_frame();
        test_timeout();
        repeat (5) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
